// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage-register state
// encoding and control-bundle width constants.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline register with
// registered InReady, flush and zeroed bubbles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  input  logic [CTRL_W-1:0] InCtrl,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [CTRL_W-1:0] OutCtrl,
  input  logic              Flush,
  output logic [1:0]        Count
);

  stage_state_e      state, state_nx;
  logic [DATA_W-1:0] m_data, m_data_nx;
  logic [CTRL_W-1:0] m_ctrl, m_ctrl_nx;
  logic [DATA_W-1:0] s_data, s_data_nx;
  logic [CTRL_W-1:0] s_ctrl, s_ctrl_nx;
  logic              rdy;
  logic              accept;
  logic              issue;

  assign accept   = InValid & rdy;
  assign OutValid = (state != EMPTY);
  assign issue    = OutValid & OutReady;
  assign InReady  = rdy;
  assign Count    = state;
  assign OutData  = OutValid ? m_data : '0;
  assign OutCtrl  = OutValid ? m_ctrl : '0;

  // Next state and entry contents; flush wins.
  always_comb begin
    state_nx  = state;
    m_data_nx = m_data;
    m_ctrl_nx = m_ctrl;
    s_data_nx = s_data;
    s_ctrl_nx = s_ctrl;
    if (Flush) begin
      state_nx  = EMPTY;
      m_data_nx = '0;
      m_ctrl_nx = '0;
      s_data_nx = '0;
      s_ctrl_nx = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx  = ONE;
            m_data_nx = InData;
            m_ctrl_nx = InCtrl;
          end
        end
        ONE: begin
          if (accept && issue) begin
            m_data_nx = InData;
            m_ctrl_nx = InCtrl;
          end else if (accept) begin
            state_nx  = FULL;
            s_data_nx = InData;
            s_ctrl_nx = InCtrl;
          end else if (issue) begin
            state_nx  = EMPTY;
            m_data_nx = '0;
            m_ctrl_nx = '0;
          end
        end
        FULL: begin
          if (issue) begin
            state_nx  = ONE;
            m_data_nx = s_data;
            m_ctrl_nx = s_ctrl;
            s_data_nx = '0;
            s_ctrl_nx = '0;
          end
        end
        default: begin
          state_nx  = EMPTY;
          m_data_nx = '0;
          m_ctrl_nx = '0;
          s_data_nx = '0;
          s_ctrl_nx = '0;
        end
      endcase
    end
  end

  // State, entries and registered ready.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= EMPTY;
      m_data <= '0;
      m_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
      rdy    <= 1'b0;
    end else begin
      state  <= state_nx;
      m_data <= m_data_nx;
      m_ctrl <= m_ctrl_nx;
      s_data <= s_data_nx;
      s_ctrl <= s_ctrl_nx;
      rdy    <= (state_nx != FULL);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table,
// async reset sequence and queue-model random run.
module tb_pipe_stage_reg;

  logic        Clk;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [31:0] InData;
  logic [31:0] InCtrl;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic [31:0] OutCtrl;
  logic        Flush;
  logic [1:0]  Count;

  int passed;
  int total;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(32)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .InValid(InValid),
    .InReady(InReady),
    .InData(InData),
    .InCtrl(InCtrl),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .OutData(OutData),
    .OutCtrl(OutCtrl),
    .Flush(Flush),
    .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ctrl_of(
    input logic [31:0] d);
    return {d[15:0], ~d[15:0]} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic iv,
                       input logic ordy,
                       input logic fl,
                       input logic [31:0] d);
    InValid  = iv;
    OutReady = ordy;
    Flush    = fl;
    InData   = d;
    InCtrl   = ctrl_of(d);
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag,
                           input logic ev,
                           input logic [31:0] ed,
                           input logic [1:0] ec,
                           input logic er);
    check({tag, " valid"}, {31'd0, OutValid}, {31'd0, ev});
    check({tag, " data"}, OutData, ed);
    check({tag, " ctrl"}, OutCtrl,
          ev ? ctrl_of(ed) : 32'd0);
    check({tag, " count"}, {30'd0, Count}, {30'd0, ec});
    check({tag, " ready"}, {31'd0, InReady}, {31'd0, er});
  endtask

  task automatic do_reset();
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    cycle();
  endtask

  function automatic void add(
    input logic iv, input logic ordy, input logic fl,
    input logic [31:0] d, input logic ev,
    input logic [31:0] ed, input logic [1:0] ec,
    input logic er);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
    v.ev = ev; v.ed = ed; v.ec = ec; v.er = er;
    vecs.push_back(v);
  endfunction

  logic [31:0] q[$];
  logic        m_rdy;
  logic        r_iv, r_or, r_fl;
  logic [31:0] r_d;
  int          seen;

  initial begin
    passed = 0;
    total  = 0;
    Rst_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);

    // pass-through, bubble, stall/fill, flushes
    add(1, 1, 0, 32'h11, 1, 32'h11, 1, 1);
    add(1, 1, 0, 32'h22, 1, 32'h22, 1, 1);
    add(1, 1, 0, 32'h33, 1, 32'h33, 1, 1);
    add(0, 1, 0, 32'h00, 0, 32'h00, 0, 1);
    add(1, 0, 0, 32'hA0, 1, 32'hA0, 1, 1);
    add(1, 0, 0, 32'hA1, 1, 32'hA0, 2, 0);
    add(1, 0, 0, 32'hB7, 1, 32'hA0, 2, 0);
    add(0, 1, 0, 32'h00, 1, 32'hA1, 1, 1);
    add(0, 1, 0, 32'h00, 0, 32'h00, 0, 1);
    add(1, 0, 0, 32'hC0, 1, 32'hC0, 1, 1);
    add(1, 0, 0, 32'hC1, 1, 32'hC0, 2, 0);
    add(1, 1, 1, 32'hFF, 0, 32'h00, 0, 1);
    add(0, 1, 0, 32'h00, 0, 32'h00, 0, 1);
    add(1, 0, 0, 32'hD0, 1, 32'hD0, 1, 1);
    add(1, 1, 1, 32'hEE, 0, 32'h00, 0, 1);
    add(0, 1, 0, 32'h00, 0, 32'h00, 0, 1);

    // reset state, then an offer during the release edge
    #2;
    check_all("reset", 1'b0, 32'd0, 2'd0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h99);
    cycle();
    check_all("release", 1'b0, 32'd0, 2'd0, 1'b1);

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].d);
      cycle();
      check_all($sformatf("row%0d", i), vecs[i].ev,
                vecs[i].ed, vecs[i].ec, vecs[i].er);
    end

    // async reset while in ONE, between edges
    @(negedge Clk);
    drive(1'b1, 1'b0, 1'b0, 32'h55);
    cycle();
    check_all("pre_rst", 1'b1, 32'h55, 2'd1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    Rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'd0, 2'd0, 1'b0);
    cycle();
    #2;
    Rst_n = 1'b1;
    #1;
    check_all("rel_pre_edge", 1'b0, 32'd0, 2'd0, 1'b0);
    cycle();
    check_all("rel_post_edge", 1'b0, 32'd0, 2'd0, 1'b1);

    // random run against a queue model
    do_reset();
    q.delete();
    m_rdy = 1'b1;
    seen  = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      r_iv = 1'($urandom_range(0, 99) < 60);
      r_or = 1'($urandom_range(0, 99) < 55);
      r_fl = 1'($urandom_range(0, 99) < 4);
      r_d  = $urandom;
      drive(r_iv, r_or, r_fl, r_d);
      @(posedge Clk);
      if (r_fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && r_or) begin
          void'(q.pop_front());
          seen++;
        end
        if (r_iv && m_rdy)
          q.push_back(r_d);
      end
      m_rdy = (q.size() < 2);
      #1;
      check_all($sformatf("rnd%0d", n), q.size() > 0,
                q.size() > 0 ? q[0] : 32'd0,
                2'(q.size()), m_rdy);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
